// File: rtl/mips16_pkg.sv
// mips16_pkg: shared types and constants for the mips16_sc program-load path.
package mips16_pkg;

    localparam int INSTR_W   = 32;
    localparam int LEN_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: shifts bytes MSB-first into an instruction word and pulses word_valid
// the cycle after the fourth byte lands.
module byte_assembler
    import mips16_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    logic [1:0] idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word       <= '0;
            idx        <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= shift && !clear && idx == 2'd3;
            if (clear)
                idx <= '0;
            else if (shift) begin
                word <= {word[INSTR_W-9:0], byte_in};
                idx  <= idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams a length-prefixed byte image into instruction memory, stalling the core
// until loaded. Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_loader
    import mips16_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_stall,
    output logic               done,
    output logic               error,
    output logic [15:0]        word_count
);

    localparam int                LEN_W   = 8 * LEN_BYTES;
    localparam logic [LEN_W:0]    MAX_LEN = (LEN_W + 1)'(DEPTH);
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t            FINISH  = CHECK;
`else
    localparam state_t            FINISH  = DONE;
`endif

    state_t               state, state_nxt;
    logic [LEN_W-1:0]     len, len_rx;
    logic [INSTR_W-1:0]   word;
    logic [15:0]          count_inc;
    logic                 word_valid, xfer, go, last_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign xfer      = byte_valid && byte_ready;
    assign go        = start && (state == IDLE || state == DONE || state == ERROR);
    assign count_inc = word_count + 16'd1;
    assign last_word = word_valid && count_inc == len;
    assign len_rx    = {len[LEN_W-1:8], byte_in};

    byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (go),
        .shift      (xfer && state == LOAD),
        .byte_in    (byte_in),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len        <= '0;
            word_count <= '0;
        end else begin
            if (go)
                word_count <= '0;
            else if (word_valid)
                word_count <= count_inc;
            if (xfer && state == LEN_HI)
                len[LEN_W-1:8] <= byte_in;
            if (xfer && state == LEN_LO)
                len[7:0] <= byte_in;
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            csum <= '0;
        else if (go)
            csum <= '0;
        else if (xfer && state == LOAD)
            csum <= csum ^ byte_in;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: state_nxt = start ? LEN_HI : state;
            LEN_HI:            state_nxt = xfer ? LEN_LO : state;
            LEN_LO:            state_nxt = !xfer ? state :
                                           len_rx == '0 ? FINISH :
                                           {1'b0, len_rx} > MAX_LEN ? ERROR : LOAD;
            LOAD:              state_nxt = last_word ? FINISH : state;
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHECK:             state_nxt = !xfer ? state : byte_in == csum ? DONE : ERROR;
`endif
            default:           state_nxt = IDLE;
        endcase
    end

    // The cycle that writes the final word must not swallow a byte belonging to what follows.
    always_comb begin
        byte_ready = state == LEN_HI || state == LEN_LO || state == CHECK ||
                     (state == LOAD && !last_word);
        imem_we    = word_valid;
        imem_addr  = word_count[ADDR_W-1:0];
        imem_wdata = word;
        cpu_stall  = state != DONE;
        done       = state == DONE;
        error      = state == ERROR;
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized self-checking bench for instr_loader against a stream-level model.
module tb_instr_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready, imem_we, cpu_stall, done, error;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [15:0]       word_count;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clock = ~clock;

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_stall  (cpu_stall),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always @(negedge clock) begin
        if (imem_we) begin
            wr_addr.push_back(32'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] d[$]);
        logic [7:0] x = 8'h00;
        foreach (d[i]) x ^= d[i];
        return x;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ":byte_ready"}, 32'(byte_ready), 0);
        check({tag, ":imem_we"},    32'(imem_we), 0);
        check({tag, ":imem_addr"},  32'(imem_addr), 0);
        check({tag, ":imem_wdata"}, imem_wdata, 0);
        check({tag, ":cpu_stall"},  32'(cpu_stall), 1);
        check({tag, ":done"},       32'(done), 0);
        check({tag, ":error"},      32'(error), 0);
        check({tag, ":word_count"}, 32'(word_count), 0);
    endtask

    task automatic send(input logic [7:0] s[$], input int glo, input int ghi);
        int   n;
        logic ok;
        foreach (s[i]) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(ghi, glo)) begin
                @(posedge clock); #1;
            end
            byte_valid = 1'b1;
            byte_in    = s[i];
            n          = 0;
            do begin
                @(negedge clock);
                ok = byte_ready;
                @(posedge clock); #1;
                n++;
            end while (!ok && n < 20);
            if (!ok) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    // Model: header N, then 4N big-endian data bytes (plus XOR byte when checksummed).
    task automatic run_load(input string tag, input logic [15:0] n, input logic [7:0] data[$],
                            input logic [7:0] cks, input int glo, input int ghi, input int poke);
        logic [7:0]  s[$];
        logic [7:0]  head[$];
        logic [7:0]  tail[$];
        logic        exp_err;
        int          exp_lat, nw, k;
        logic [31:0] w;
        s = {n[15:8], n[7:0]};
        exp_err = n > DEPTH;
        nw = exp_err ? 0 : int'(n);
        if (!exp_err) begin
            s = {s, data};
`ifdef INSTR_LOADER_CHECKSUM_EN
            s.push_back(cks);
`endif
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (cks != xor_of(data)) exp_err = 1'b1;
        exp_lat = 1;
`else
        exp_lat = (n == 0 || n > DEPTH) ? 1 : 2;
`endif
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        check({tag, ":stall_on_start"}, 32'(cpu_stall), 1);
        check({tag, ":count_cleared"}, 32'(word_count), 0);
        check({tag, ":done_cleared"}, 32'(done), 0);
        if (poke > 0 && poke < s.size()) begin
            head = s[0:poke-1];
            tail = s[poke:$];
            send(head, glo, ghi);
            pulse_start();
            send(tail, glo, ghi);
        end else
            send(s, glo, ghi);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!done && !error && k < 100);
        #1;
        check({tag, ":latency"}, k, exp_lat);
        check({tag, ":done"}, 32'(done), 32'(!exp_err));
        check({tag, ":error"}, 32'(error), 32'(exp_err));
        check({tag, ":cpu_stall"}, 32'(cpu_stall), 32'(exp_err));
        check({tag, ":byte_ready"}, 32'(byte_ready), 0);
        check({tag, ":word_count"}, 32'(word_count), nw);
        check({tag, ":writes"}, wr_addr.size(), nw);
        for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
            w = {data[4*i], data[4*i+1], data[4*i+2], data[4*i+3]};
            check({tag, ":addr"}, wr_addr[i], i % (1 << ADDR_W));
            check({tag, ":data"}, wr_data[i], w);
        end
    endtask

    initial begin
        logic [7:0] basic[$];
        logic [7:0] none[$];
        logic [7:0] part[$];
        logic [7:0] d[$];
        int         n;
        basic = {8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h01, 8'h18, 8'h80};
        repeat (2) @(posedge clock);
        #1;
        reset_checks("reset");
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle:byte_ready", 32'(byte_ready), 0);

        run_load("basic", 16'd2, basic, xor_of(basic), 0, 0, -1);
        run_load("gaps", 16'd2, basic, xor_of(basic), 3, 3, -1);
        run_load("n0", 16'd0, none, 8'h00, 0, 1, -1);
        run_load("over", 16'(DEPTH + 1), none, 8'h00, 0, 0, -1);

        part = {8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_start();
        send(part, 0, 1);
        check("midload:count_before", 32'(word_count), 1);
        #2 reset = 1'b1;
        #1 reset_checks("midload");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        run_load("reload", 16'd2, basic, xor_of(basic), 0, 1, -1);

        run_load("start_ignored", 16'd2, basic, xor_of(basic), 0, 1, 5);
        d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load("overwrite", 16'd1, d, xor_of(d), 0, 2, -1);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(6, 1);
            d.delete();
            for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom));
            run_load("rand", 16'(n), d, xor_of(d), 0, 2, -1);
        end

        d.delete();
        for (int i = 0; i < 4 * DEPTH; i++) d.push_back(8'($urandom));
        run_load("depth", 16'(DEPTH), d, xor_of(d), 0, 0, -1);

`ifdef INSTR_LOADER_CHECKSUM_EN
        d = {8'hAA, 8'h55, 8'h0F, 8'hF0};
        run_load("cks_ok", 16'd1, d, 8'h00, 0, 1, -1);
        run_load("cks_bad", 16'd1, d, 8'h01, 0, 1, -1);
        run_load("cks_n0_bad", 16'd0, none, 8'h5A, 0, 1, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream program-load stage for the mips16_sc core. It accepts a byte stream over a valid/ready handshake and assembles the bytes into 32-bit instruction words.
- It writes each word into instruction memory at sequential addresses from 0, and holds the core stalled until the load completes.
- It replaces file-based memory preloading in system-level runs.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, maximum loadable words; must be <= 2**ADDR_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Only honoured in IDLE, DONE or ERROR.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts byte_in this cycle. A transfer occurs when byte_valid && byte_ready.
- imem_we  out  1  instruction memory write enable, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  assembled instruction word.
- cpu_stall  out  1  holds the core (drives instr_stall); high while a load is in progress.
- done  out  1  load finished successfully; level signal.
- error  out  1  load aborted; level signal.
- word_count  out  16  words written so far.

Behaviour:
- Reset is asynchronous and active-high; clock is the single clock.
- Reset values:
  - state = IDLE.
  - byte_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - cpu_stall = 1, so the core never runs unloaded code.
  - done = 0, error = 0, word_count = 0.
- Stream format: 16-bit word count N (MSB byte first), then 4*N bytes. Each word is big-endian: byte 0 goes to [31:24], byte 3 goes to [7:0].
- States:
  - IDLE: byte_ready = 0. start -> LEN_HI, clear word_count, clear done/error.
  - LEN_HI: byte_ready = 1. A transfer latches N[15:8] -> LEN_LO.
  - LEN_LO: byte_ready = 1. A transfer latches N[7:0].
    - N == 0 -> DONE.
    - N > DEPTH -> ERROR.
    - Otherwise -> LOAD, with byte index = 0.
  - LOAD: byte_ready = 1. Each transfer shifts the byte into the assembly register and increments the byte index (2 bits, wraps).
    - On the 4th byte, the next cycle drives imem_we = 1, imem_addr = word_count[ADDR_W-1:0], imem_wdata = assembled word, and increments word_count.
    - When the incremented word_count equals N -> DONE, in that same cycle.
    - A byte accepted in the same cycle as imem_we is legal; the write data is already captured.
  - DONE: done = 1, cpu_stall = 0, byte_ready = 0. start -> LEN_HI and reasserts cpu_stall the next cycle.
  - ERROR: error = 1, cpu_stall = 1, byte_ready = 0. Only start or reset leave this state.
- Latency: a word's last byte accepted at cycle t gives imem_we at t+1, and done at t+2 for the last word.
- byte_valid low stalls progress indefinitely; no timeout.
- start while in LEN_HI, LEN_LO or LOAD is ignored.
- Reset mid-load aborts immediately. Already-written memory contents are not cleared.

Optional Feature:
- INSTR_LOADER_CHECKSUM_EN defined: after the last data byte, a state CHECK accepts one further byte.
  - That byte must equal the XOR of all 4*N data bytes (length bytes excluded).
  - Match -> DONE. Mismatch -> ERROR.
  - For N == 0 the checksum byte must be 8'h00.
- Undefined: there is no CHECK state, and LOAD goes directly to DONE.

Decomposition:
- Shared package mips16_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, LOAD, CHECK, DONE, ERROR);
  - the INSTR_W = 32 constant;
  - the LEN_BYTES = 2 constant.
- One natural sub-module, byte_assembler: a 4-byte shift register with an index counter and a word_valid pulse. The FSM stays in instr_loader.

Test Plan:
- Basic load: reset, start, stream 00 02, 20 01 00 05, 00 01 18 80 -> imem writes addr0 = 32'h20010005 and addr1 = 32'h00011880. done = 1 two cycles after the last byte, cpu_stall = 0, word_count = 2.
- Back-pressure gaps: same stream with byte_valid deasserted for 3 cycles between every byte -> identical writes, and imem_we is never asserted during gaps.
- Boundary lengths:
  - N = 0 (bytes 00 00) -> DONE right after LEN_LO, no writes.
  - N = DEPTH+1 (01 01 when DEPTH = 256) -> ERROR, cpu_stall stays 1, byte_ready = 0.
- Reset mid-load: assert reset after 6 data bytes -> all outputs return to reset values asynchronously. A fresh start then reloads from addr0.
- Start ignored / reload: a start pulse during LOAD has no effect. A start after DONE reasserts cpu_stall and a second load of 1 word overwrites addr0.
- Checksum (INSTR_LOADER_CHECKSUM_EN): N = 1, data AA 55 0F F0, checksum 00 -> DONE. Checksum 01 -> ERROR.
